// File: rtl/mux_pkg.sv
// Shared constants for the channel multiplexer/arbiter.
// mode input encoding: fixed channel select or round-robin arbitration.
package mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first requester at or after ptr, wrapping modulo CH.
// Purely combinational; all arbitration state lives in the parent.
module rr_pick #(
    parameter int CH = 4,
    parameter int SW = $clog2(CH)
) (
    input  logic [CH-1:0] req,
    input  logic [SW-1:0] ptr,
    output logic [CH-1:0] gnt,
    output logic [SW-1:0] idx,
    output logic          gnt_valid
);

    // Scan offsets from farthest to nearest so the nearest requester is the last write.
    always_comb begin
        gnt       = '0;
        idx       = '0;
        gnt_valid = 1'b0;
        for (int k = CH - 1; k >= 0; k--) begin
            int c;
            c = int'(ptr) + k;
            if (c >= CH) begin
                c = c - CH;
            end
            if (req[c]) begin
                gnt       = '0;
                gnt[c]    = 1'b1;
                idx       = SW'(c);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// Channel multiplexer with fixed-select or round-robin arbitration feeding a
// single registered output stage with valid/ready handshake.
module mux_arb
    import mux_pkg::*;
#(
    parameter  int WIDTH = 2,
    parameter  int CH    = 4,
    localparam int SW    = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [SW-1:0]       sel,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic [CH-1:0]       in_valid,
    output logic [CH-1:0]       in_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [SW-1:0]       out_sel,
    output logic                out_valid,
    input  logic                out_ready
);

    logic [WIDTH-1:0] ch_data [CH];

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic [SW-1:0]    ptr_reg, ptr_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [SW-1:0]    out_sel_reg, out_sel_next;
    logic             out_valid_reg, out_valid_next;

    logic             load;
    logic [CH-1:0]    rr_gnt, fix_gnt, gnt_onehot;
    logic [SW-1:0]    rr_idx, gnt_idx;
    logic             rr_valid, fix_valid, gnt_valid;
    logic [WIDTH-1:0] gnt_data;

    assign load = !out_valid_reg || out_ready;

    rr_pick #(.CH(CH), .SW(SW)) u_pick (
        .req       (in_valid),
        .ptr       (ptr_reg),
        .gnt       (rr_gnt),
        .idx       (rr_idx),
        .gnt_valid (rr_valid)
    );

    // Matching sel against every legal index means sel >= CH never grants.
    always_comb begin
        fix_gnt   = '0;
        fix_valid = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (sel == SW'(i) && in_valid[i]) begin
                fix_gnt[i] = 1'b1;
                fix_valid  = 1'b1;
            end
        end
    end

    assign gnt_valid  = (mode == MODE_RR) ? rr_valid : fix_valid;
    assign gnt_onehot = (mode == MODE_RR) ? rr_gnt   : fix_gnt;
    assign gnt_idx    = (mode == MODE_RR) ? rr_idx   : sel;

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (gnt_onehot[i]) begin
                gnt_data = ch_data[i];
            end
        end
    end

    // Grant vectors are already zero when nothing is granted.
    assign in_ready = (load && rst_n) ? gnt_onehot : '0;

    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_sel_next   = out_sel_reg;
        ptr_next       = ptr_reg;
        if (load) begin
            out_valid_next = gnt_valid;
            if (gnt_valid) begin
                out_data_next = gnt_data;
                out_sel_next  = gnt_idx;
                if (mode == MODE_RR) begin
                    ptr_next = (gnt_idx == SW'(CH - 1)) ? '0 : gnt_idx + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            ptr_reg       <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_sel_reg   <= out_sel_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb: directed scenarios plus random traffic,
// checked against a transaction-level reference model of the arbiter.
module tb_mux_arb;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] in_data;
    logic [3:0] in_valid, in_ready;
    logic [1:0] out_data, out_sel;
    logic       out_valid, out_ready;

    logic       mode3;
    logic [1:0] sel3;
    logic [5:0] in_data3;
    logic [2:0] in_valid3, in_ready3;
    logic [1:0] out_data3, out_sel3;
    logic       out_valid3, out_ready3;

    mux_arb #(.WIDTH(2), .CH(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_arb #(.WIDTH(2), .CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    // Reference model: the output beat currently held and the RR start point.
    bit         m_valid;
    logic [1:0] m_data, m_sel;
    int         m_ptr;
    logic [3:0] last_ready;

    task automatic model_reset();
        m_valid = 0;
        m_data  = 2'b00;
        m_sel   = 2'b00;
        m_ptr   = 0;
    endtask

    // One clock of traffic with the inputs currently driven; checks in_ready before
    // the edge and the registered outputs after it.
    task automatic step(input string tag);
        int         g;
        bit         gv;
        bit         ld;
        logic [3:0] exp_rdy;
        #1;
        gv = 0;
        g  = 0;
        if (mode == 1'b0) begin
            if (in_valid[sel]) begin
                gv = 1;
                g  = int'(sel);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (!gv && in_valid[c]) begin
                    gv = 1;
                    g  = c;
                end
            end
        end
        ld      = !m_valid || out_ready;
        exp_rdy = (ld && gv) ? 4'(1 << g) : 4'b0000;
        last_ready = in_ready;
        n_cmp++;
        if (in_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL %s in_ready: got %b expected %b", tag, in_ready, exp_rdy);
        end
        @(posedge clk);
        if (ld) begin
            if (gv) begin
                m_valid = 1;
                m_data  = in_data[g*2 +: 2];
                m_sel   = 2'(g);
                if (mode) m_ptr = (g + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        n_cmp++;
        if (out_valid !== m_valid) begin
            n_bad++;
            $display("FAIL %s out_valid: got %b expected %b", tag, out_valid, m_valid);
        end
        n_cmp++;
        if (out_data !== m_data) begin
            n_bad++;
            $display("FAIL %s out_data: got %b expected %b", tag, out_data, m_data);
        end
        n_cmp++;
        if (out_sel !== m_sel) begin
            n_bad++;
            $display("FAIL %s out_sel: got %0d expected %0d", tag, out_sel, m_sel);
        end
        n_txn++;
        $display("txn %0d %s mode=%0d sel=%0d vld=%b ordy=%b irdy=%b -> ov=%b od=%b os=%0d",
                 n_txn, tag, mode, sel, in_valid, out_ready, last_ready, out_valid, out_data, out_sel);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 1'b0; sel = 2'd0; in_data = 8'hE4; in_valid = 4'b1111; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; in_data3 = 6'h00; in_valid3 = 3'b000; out_ready3 = 1'b1;
        model_reset();
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 2'b00 || out_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL reset outputs: got v=%b d=%b s=%0d expected 0/00/0", out_valid, out_data, out_sel);
        end
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset in_ready: got %b expected 0000", in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {2'b11, 2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step("fixed");
            n_cmp++;
            if (out_data !== 2'(i) || out_sel !== 2'(i)) begin
                n_bad++;
                $display("FAIL fixed_seq: got d=%b s=%0d expected d=%b s=%0d", out_data, out_sel, 2'(i), i);
            end
        end
    endtask

    task automatic test_rr_sparse();
        int exp_seq [4] = '{1, 3, 1, 3};
        mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'($urandom);
            step("rr_sparse");
            n_cmp++;
            if (out_sel !== 2'(exp_seq[i]) || last_ready !== 4'(1 << exp_seq[i])) begin
                n_bad++;
                $display("FAIL rr_sparse: got s=%0d rdy=%b expected s=%0d", out_sel, last_ready, exp_seq[i]);
            end
        end
    endtask

    task automatic test_rr_all();
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'($urandom);
            step("rr_all");
            n_cmp++;
            if (out_sel !== 2'(exp_seq[i]) || last_ready !== 4'(1 << exp_seq[i])) begin
                n_bad++;
                $display("FAIL rr_all: got s=%0d rdy=%b expected s=%0d", out_sel, last_ready, exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] d0, s0;
        int         nxt;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = 8'($urandom);
        step("bp_load");
        d0 = m_data;
        s0 = m_sel;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            mode = 1'($urandom);
            sel = 2'($urandom);
            step("bp_stall");
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== d0 || out_sel !== s0 || last_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL bp_hold: got v=%b d=%b s=%0d rdy=%b expected 1/%b/%0d/0000",
                         out_valid, out_data, out_sel, last_ready, d0, s0);
            end
        end
        mode = 1'b1; out_ready = 1'b1; in_data = 8'($urandom);
        nxt = (int'(s0) + 1) % 4;
        step("bp_release");
        n_cmp++;
        if (out_valid !== 1'b1 || out_sel !== 2'(nxt) || last_ready !== 4'(1 << nxt)) begin
            n_bad++;
            $display("FAIL bp_release: got v=%b s=%0d rdy=%b expected v=1 s=%0d", out_valid, out_sel, last_ready, nxt);
        end
    endtask

    task automatic test_fixed_novalid();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1011; out_ready = 1'b1;
        in_data = 8'($urandom);
        step("fix_novalid");
        n_cmp++;
        if (out_valid !== 1'b0 || last_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL fix_novalid: got v=%b rdy=%b expected v=0 rdy=0000", out_valid, last_ready);
        end
    endtask

    task automatic test_ch3();
        in_data3 = 6'($urandom);
        mode3 = 1'b0; sel3 = 2'd2; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #1;
        n_cmp++;
        if (in_ready3 !== 3'b100) begin
            n_bad++;
            $display("FAIL ch3_sel2_ready: got %b expected 100", in_ready3);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid3 !== 1'b1 || out_sel3 !== 2'd2 || out_data3 !== in_data3[5:4]) begin
            n_bad++;
            $display("FAIL ch3_sel2_out: got v=%b s=%0d d=%b expected 1/2/%b", out_valid3, out_sel3, out_data3, in_data3[5:4]);
        end
        @(negedge clk);
        sel3 = 2'd3;
        #1;
        n_cmp++;
        if (in_ready3 !== 3'b000) begin
            n_bad++;
            $display("FAIL ch3_sel3_ready: got %b expected 000", in_ready3);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid3 !== 1'b0 || out_sel3 !== 2'd2) begin
            n_bad++;
            $display("FAIL ch3_sel3_out: got v=%b s=%0d expected v=0 s=2", out_valid3, out_sel3);
        end
        $display("txn ch3 sel=3 -> ov=%b os=%0d", out_valid3, out_sel3);
        @(negedge clk);
        in_valid3 = 3'b000;
    endtask

    task automatic test_reset_midstream();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; in_data = 8'hFF;
        step("rst_pre");
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 2'b00 || out_sel !== 2'd0 || in_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_mid: got v=%b d=%b s=%0d rdy=%b expected 0/00/0/0000", out_valid, out_data, out_sel, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        out_ready = 1'b1; in_data = 8'($urandom);
        step("rst_post");
        n_cmp++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_restart: got v=%b s=%0d expected v=1 s=0", out_valid, out_sel);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step("random");
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_sparse();
        test_rr_all();
        test_backpressure();
        test_fixed_novalid();
        test_ch3();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 2, meaning data bits per channel.
REQ-002 SHALL have parameter CH, default 4, meaning input channel count (2..16).
REQ-003 SHALL have localparam SW = $clog2(CH), meaning select width.
REQ-004 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-008 SHALL have port sel  input  SW  channel index used in fixed mode.
REQ-009 SHALL have port in_data  input  CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port in_valid  input  CH  per-channel beat present.
REQ-011 SHALL have port in_ready  output  CH  per-channel beat accepted this cycle.
REQ-012 SHALL have port out_data  output  WIDTH  registered selected beat.
REQ-013 SHALL have port out_sel  output  SW  index of the channel that supplied out_data.
REQ-014 SHALL have port out_valid  output  1  out_data holds an unconsumed beat.
REQ-015 SHALL have port out_ready  input  1  downstream accepts beat.

Function
REQ-016 The block SHALL define load = !out_valid || out_ready (combinational).
REQ-017 Fixed mode: grant SHALL be channel sel when in_valid[sel]=1; otherwise no grant; sel >= CH SHALL give no grant.
REQ-018 RR mode: grant SHALL be the first i with in_valid[i]=1, scanning ptr, ptr+1, ... modulo CH; no valid gives no grant.
REQ-019 in_ready[g] SHALL be 1 only for granted channel g and only when load=1; all other bits 0; at most one bit high.
REQ-020 A transfer on channel g SHALL be in_valid[g] && in_ready[g]; on the next edge out_data <= channel g data, out_sel <= g, out_valid <= 1.
REQ-021 Latency SHALL be exactly 1 cycle from input transfer to out_valid; zero-bubble throughput of 1 beat/cycle when out_ready stays 1.
REQ-022 When load=1 and no grant, out_valid SHALL go 0 on the next edge; out_data/out_sel SHALL hold their values.
REQ-023 When out_valid=1 and out_ready=0, out_data, out_sel, out_valid SHALL hold; in_ready SHALL be all 0.
REQ-024 RR pointer ptr (SW bits) SHALL update to (g+1) mod CH only on a transfer in RR mode; wrap from CH-1 to 0.
REQ-025 ptr SHALL hold in fixed mode and on cycles with no transfer.
REQ-026 Changes of mode or sel SHALL affect only arbitration in the same cycle; a held output beat SHALL be unaffected.
REQ-027 No input beat SHALL be dropped or duplicated; in_valid may drop without a transfer and is not required to be sticky.

Reset
REQ-028 While rst_n=0: out_valid=0, out_data=0, out_sel=0, ptr=0, asynchronously.
REQ-029 in_ready SHALL be all 0 while rst_n=0; a held beat is discarded on reset mid-operation.
REQ-030 Reset release SHALL be synchronous to clk; first transfer possible on the first edge after release.

Structure
REQ-031 Constants MODE_FIXED=1'b0 and MODE_RR=1'b1 SHALL live in shared package mux_pkg.
REQ-032 RR priority pick SHALL be a sub-module rr_pick (CH-bit request, SW-bit pointer in; one-hot grant, index, grant-valid out; purely combinational).
REQ-033 All state SHALL be in mux_arb; no latches; no multicycle paths.

Verification
REQ-034 Fixed mode, CH=4, WIDTH=2, data 00/01/10/11, all valid, out_ready=1, sel 0,1,2,3 on consecutive cycles -> out_data 00,01,10,11 each one cycle later, out_sel matching.
REQ-035 RR mode, all four valid continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 (wrap), in_ready one-hot rotating.
REQ-036 RR mode, only channels 1 and 3 valid -> out_sel 1,3,1,3; ptr skips idle channels.
REQ-037 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data/out_sel stable, in_ready=0000; out_ready=1 -> next beat loads same cycle, no bubble.
REQ-038 Fixed mode with in_valid[sel]=0 -> no grant, out_valid falls after current beat consumed; sel=3 with CH=3 -> no grant.
REQ-039 Assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately; after release RR restarts at channel 0.
